// File: rtl/aes_pkg.sv
// Shared AES definitions: schedule sizes, key-schedule FSM encodings and the
// GF(2^8) helpers (xtime, multiply, S-box byte) used by the key schedule
// and the cipher datapath.
package aes_pkg;

    localparam int NK = 4;   // key words
    localparam int NR = 10;  // rounds
    localparam int NW = 44;  // schedule words, NK*(NR+1)

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_EXPAND = 2'd1,
        KS_DONE   = 2'd2
    } ks_state_e;

    // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed rather than tabulated: inverse as b^254 (0 maps to 0),
    // followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        r    = 8'h01;
        base = b;
        e    = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/s_box.sv
// 32-bit bytewise AES S-box (SubWord). Purely combinational.
//   data_i : input word
//   data_o : each byte of data_i substituted through the S-box
module s_box
    import aes_pkg::*;
(
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign data_o[8*i +: 8] = sbox_byte(data_i[8*i +: 8]);
    end

endmodule

// File: rtl/aes_key_sched.sv
// AES-128 key expansion, one schedule word per clock.
//   clk     : rising-edge clock
//   reset   : synchronous active-high reset
//   key     : cipher key, W0 = key[127:96] .. W3 = key[31:0]
//   trigger : start request, accepted in IDLE or DONE
//   w       : full schedule, word Wn at w[32n +: 32]
//   done    : schedule complete; rises 40 edges after the accepting edge
module aes_key_sched
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [127:0]  key,
    input  logic          trigger,
    output logic [1407:0] w,
    output logic          done
);

    ks_state_e            state_q, state_d;
    logic [NW-1:0][31:0]  w_q, w_d;
    logic [5:0]           idx_q, idx_d;
    logic [7:0]           rcon_q, rcon_d;
    logic                 done_q, done_d;

    logic [31:0] prev_w, old_w, rot_w, sub_w, temp_w;

    // Operands for word n = idx: W(n-1) and W(n-4). Only meaningful in
    // EXPAND, where idx is always 4..43.
    assign prev_w = w_q[idx_q - 6'd1];
    assign old_w  = w_q[idx_q - 6'd4];
    assign rot_w  = {prev_w[23:0], prev_w[31:24]};

    s_box u_sub (
        .data_i (rot_w),
        .data_o (sub_w)
    );

    assign temp_w = (idx_q[1:0] == 2'b00) ? (sub_w ^ {rcon_q, 24'h0}) : prev_w;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        done_d  = done_q;
        case (state_q)
            KS_IDLE, KS_DONE: begin
                if (trigger) begin
                    w_d     = '0;
                    w_d[0]  = key[127:96];
                    w_d[1]  = key[95:64];
                    w_d[2]  = key[63:32];
                    w_d[3]  = key[31:0];
                    idx_d   = 6'd4;
                    rcon_d  = 8'h01;
                    done_d  = 1'b0;
                    state_d = KS_EXPAND;
                end
            end
            KS_EXPAND: begin
                w_d[idx_q] = old_w ^ temp_w;
                idx_d      = idx_q + 6'd1;
                if (idx_q[1:0] == 2'b00) rcon_d = xtime(rcon_q);
                if (idx_q == 6'(NW - 1)) begin
                    state_d = KS_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = KS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= KS_IDLE;
            w_q     <= '0;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign w    = w_q;
    assign done = done_q;

endmodule
